// File: rtl/clock_cfg_seq_if.sv
// Request and CLOCK-facing bus of the clock configuration sequencer.
//
// Handshake: the requester holds req_valid and the req_* fields stable until
// a rising ref_clk edge sees req_valid && req_ready. That edge is the single
// transfer point. req_ready never depends on req_valid in the same cycle.
interface clock_cfg_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_counter;
    logic [31:0] req_ref_counter;
    logic [8:0]  req_init;
    logic        clk_resetn;
    logic [31:0] clk_counter;
    logic [31:0] clk_ref_counter;
    logic [8:0]  clk_init;
    logic [2:0]  clk_status;

    // Requester plus CLOCK side of the bus.
    modport master (
        output req_valid, req_counter, req_ref_counter, req_init, clk_status,
        input  req_ready, clk_resetn, clk_counter, clk_ref_counter, clk_init
    );

    // Sequencer side of the bus.
    modport slave (
        input  req_valid, req_counter, req_ref_counter, req_init, clk_status,
        output req_ready, clk_resetn, clk_counter, clk_ref_counter, clk_init
    );
endinterface

// File: rtl/clock_cfg_seq.sv
// Configuration sequencer for the CLOCK generator.
// Each attempt holds CLOCK in reset, then waits for lock within a time limit.
// A failed attempt is retried with a stepped tuning word. Once locked, the
// sequencer watches for lock loss and restarts from the requested word.
module clock_cfg_seq #(
    parameter int unsigned RST_CYCLES   = 100,
    parameter int unsigned LOCK_TIMEOUT = 1000000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned INIT_STEP    = 16
) (
    input  logic        ref_clk,
    input  logic        resetn,
    clock_cfg_seq_if.slave bus,
    output logic        locked,
    output logic        fail,
    output logic        busy,
    output logic [3:0]  attempt,
    output logic        lock_lost,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOLD   = 3'd1,
        S_WAIT   = 3'd2,
        S_LOCKED = 3'd3,
        S_FAILED = 3'd4
    } state_t;

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [31:0]   TMO_LAST  = 32'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [8:0]    STEP      = 9'(INIT_STEP);

    state_t        state_q;
    logic          req_ready_q;
    logic          clk_resetn_q;
    logic [31:0]   clk_counter_q;
    logic [31:0]   clk_ref_counter_q;
    logic [8:0]    clk_init_q;
    logic [8:0]    init_base_q;
    logic          locked_q;
    logic          fail_q;
    logic          busy_q;
    logic [3:0]    attempt_q;
    logic          lock_lost_q;
    logic [HW-1:0] hold_cnt_q;
    logic [31:0]   tmo_cnt_q;

    logic accept;
    logic unused_searching;

    assign accept = bus.req_valid && req_ready_q;

    // The searching flag is informational only; progress is driven by lock/error.
    assign unused_searching = bus.clk_status[0];

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge ref_clk) begin
        if (!resetn) begin
            state_q           <= S_IDLE;
            req_ready_q       <= 1'b0;
            clk_resetn_q      <= 1'b0;
            clk_counter_q     <= '0;
            clk_ref_counter_q <= '0;
            clk_init_q        <= '0;
            init_base_q       <= '0;
            locked_q          <= 1'b0;
            fail_q            <= 1'b0;
            busy_q            <= 1'b0;
            attempt_q         <= '0;
            lock_lost_q       <= 1'b0;
            hold_cnt_q        <= '0;
            tmo_cnt_q         <= '0;
        end else begin
            // Lock loss is reported even when a new request wins the same edge.
            lock_lost_q <= (state_q == S_LOCKED) && !bus.clk_status[1];

            if (accept) begin
                // New request: abort whatever is running and start attempt 0.
                clk_counter_q     <= bus.req_counter;
                clk_ref_counter_q <= bus.req_ref_counter;
                clk_init_q        <= bus.req_init;
                init_base_q       <= bus.req_init;
                attempt_q         <= '0;
                locked_q          <= 1'b0;
                fail_q            <= 1'b0;
                busy_q            <= 1'b1;
                clk_resetn_q      <= 1'b0;
                hold_cnt_q        <= '0;
                req_ready_q       <= 1'b0;
                state_q           <= S_HOLD;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        req_ready_q <= 1'b1;
                    end
                    S_HOLD: begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            clk_resetn_q <= 1'b1;
                            tmo_cnt_q    <= '0;
                            state_q      <= S_WAIT;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (bus.clk_status[1]) begin
                            locked_q    <= 1'b1;
                            busy_q      <= 1'b0;
                            req_ready_q <= 1'b1;
                            state_q     <= S_LOCKED;
                        end else if (bus.clk_status[2] || tmo_cnt_q == TMO_LAST) begin
                            clk_resetn_q <= 1'b0;
                            if (attempt_q < RETRY_MAX) begin
                                attempt_q  <= attempt_q + 1'b1;
                                clk_init_q <= clk_init_q + STEP;
                                hold_cnt_q <= '0;
                                state_q    <= S_HOLD;
                            end else begin
                                fail_q      <= 1'b1;
                                busy_q      <= 1'b0;
                                req_ready_q <= 1'b1;
                                state_q     <= S_FAILED;
                            end
                        end else if (tmo_cnt_q != '1) begin
                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
                    end
                    S_LOCKED: begin
                        if (!bus.clk_status[1]) begin
                            locked_q     <= 1'b0;
                            attempt_q    <= '0;
                            clk_init_q   <= init_base_q;
                            busy_q       <= 1'b1;
                            clk_resetn_q <= 1'b0;
                            hold_cnt_q   <= '0;
                            req_ready_q  <= 1'b0;
                            state_q      <= S_HOLD;
                        end
                    end
                    S_FAILED: begin
                        fail_q <= 1'b1;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.clk_resetn      = clk_resetn_q;
    assign bus.clk_counter     = clk_counter_q;
    assign bus.clk_ref_counter = clk_ref_counter_q;
    assign bus.clk_init        = clk_init_q;
    assign locked              = locked_q;
    assign fail                = fail_q;
    assign busy                = busy_q;
    assign attempt             = attempt_q;
    assign lock_lost           = lock_lost_q;
    assign state_o             = state_q;

endmodule

// File: tb/tb_clock_cfg_seq.sv
// Bench for clock_cfg_seq: instance A uses the default timing, instance B a
// short reset and a 50-cycle lock limit. A CLOCK stand-in is driven from tasks.
module tb_clock_cfg_seq;
    localparam int RST_A  = 100;
    localparam int RST_B  = 7;
    localparam int TMO_B  = 50;
    localparam int STEP   = 16;
    localparam int NTRIES = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    clock_cfg_seq_if ifa ();
    clock_cfg_seq_if ifb ();

    logic       a_locked, a_fail, a_busy, a_lock_lost;
    logic [3:0] a_attempt;
    logic [2:0] a_state_unused;
    logic       b_locked, b_fail, b_busy, b_lock_lost;
    logic [3:0] b_attempt;
    logic [2:0] b_state_unused;

    clock_cfg_seq #(.RST_CYCLES(RST_A), .LOCK_TIMEOUT(1000000), .MAX_RETRY(3), .INIT_STEP(STEP)) dut_a (
        .ref_clk(clk), .resetn(resetn), .bus(ifa),
        .locked(a_locked), .fail(a_fail), .busy(a_busy), .attempt(a_attempt),
        .lock_lost(a_lock_lost), .state_o(a_state_unused)
    );

    clock_cfg_seq #(.RST_CYCLES(RST_B), .LOCK_TIMEOUT(TMO_B), .MAX_RETRY(3), .INIT_STEP(STEP)) dut_b (
        .ref_clk(clk), .resetn(resetn), .bus(ifb),
        .locked(b_locked), .fail(b_fail), .busy(b_busy), .attempt(b_attempt),
        .lock_lost(b_lock_lost), .state_o(b_state_unused)
    );

    int total = 0;
    int bad = 0;
    int ll_a = 0;
    logic [8:0] exp_q[$];

    // Lock-loss pulse counter for instance A.
    always @(negedge clk) if (a_lock_lost === 1'b1) ll_a++;

    // Reference: tuning word of attempt k, 9-bit modular.
    function automatic logic [8:0] exp_init(input int base, input int k);
        int v;
        v = (base + k * STEP) % 512;
        return v[8:0];
    endfunction

    // Driver: present a request on A and return on the negedge after transfer.
    task automatic send_a(input logic [31:0] c, input logic [31:0] r, input logic [8:0] i, output bit ok);
        int n = 0;
        while (ifa.req_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        ok = (ifa.req_ready === 1'b1);
        ifa.req_valid = 1'b1;
        ifa.req_counter = c;
        ifa.req_ref_counter = r;
        ifa.req_init = i;
        @(negedge clk);
        ifa.req_valid = 1'b0;
    endtask

    // CLOCK stand-in for one attempt on A: count reset-low cycles, capture the
    // config at release, search for 'delay' cycles, then answer with resp.
    task automatic attempt_a(input logic [2:0] resp, input int delay, output int low,
                             output logic [8:0] init_s, output logic [3:0] att_s);
        ifa.clk_status = 3'b000;
        low = 0;
        while (ifa.clk_resetn !== 1'b1 && low < 5000) begin
            low++;
            @(negedge clk);
        end
        init_s = ifa.clk_init;
        att_s = a_attempt;
        ifa.clk_status = 3'b001;
        repeat (delay) @(negedge clk);
        ifa.clk_status = resp;
        @(negedge clk);
        if (!resp[1]) ifa.clk_status = 3'b000;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({ifa.req_ready, ifa.clk_resetn, a_locked, a_fail, a_busy, a_attempt, a_lock_lost} !== 10'd0) begin bad++; $display("FAIL rst_a_ctrl: got %h want 0", {ifa.req_ready, ifa.clk_resetn, a_locked, a_fail, a_busy, a_attempt, a_lock_lost}); end
        total++; if ({ifa.clk_counter, ifa.clk_ref_counter, ifa.clk_init} !== 73'd0) begin bad++; $display("FAIL rst_a_data: got %h want 0", {ifa.clk_counter, ifa.clk_ref_counter, ifa.clk_init}); end
        total++; if ({ifb.req_ready, ifb.clk_resetn, b_locked, b_fail, b_busy, b_attempt, b_lock_lost} !== 10'd0) begin bad++; $display("FAIL rst_b_ctrl: got %h want 0", {ifb.req_ready, ifb.clk_resetn, b_locked, b_fail, b_busy, b_attempt, b_lock_lost}); end
        resetn = 1'b1;
        @(negedge clk);
        total++; if (ifa.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", ifa.req_ready); end
    endtask

    task automatic test_first_lock();
        bit ok; int low; logic [8:0] ini; logic [3:0] att;
        send_a(32'd5000, 32'd10, 9'd20, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL first_accept: got %b want 1", ok); end
        total++; if ({ifa.req_ready, a_busy} !== 2'b01) begin bad++; $display("FAIL first_hold_flags: got %b want 01", {ifa.req_ready, a_busy}); end
        attempt_a(3'b010, 300, low, ini, att);
        total++; if (low !== RST_A) begin bad++; $display("FAIL first_low: got %0d want %0d", low, RST_A); end
        total++; if (ini !== 9'd20) begin bad++; $display("FAIL first_init: got %0d want 20", ini); end
        total++; if ({ifa.clk_counter, ifa.clk_ref_counter} !== {32'd5000, 32'd10}) begin bad++; $display("FAIL first_cfg: got %0d/%0d want 5000/10", ifa.clk_counter, ifa.clk_ref_counter); end
        total++; if ({a_locked, a_fail, a_busy, a_attempt, ifa.req_ready, ifa.clk_resetn} !== 9'b100_0000_11) begin bad++; $display("FAIL first_state: got %b want 100000011", {a_locked, a_fail, a_busy, a_attempt, ifa.req_ready, ifa.clk_resetn}); end
    endtask

    task automatic test_retry_lock();
        bit ok; int low; logic [8:0] ini; logic [3:0] att;
        send_a(32'd5000, 32'd10, 9'd20, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL retry_accept: got %b want 1", ok); end
        for (int k = 0; k < 3; k++) begin
            // Last attempt raises lock and error together; lock must win.
            attempt_a((k < 2) ? 3'b100 : 3'b110, $urandom_range(0, 40), low, ini, att);
            total++; if (low !== RST_A) begin bad++; $display("FAIL retry_low%0d: got %0d want %0d", k, low, RST_A); end
            total++; if (ini !== exp_init(20, k)) begin bad++; $display("FAIL retry_init%0d: got %0d want %0d", k, ini, exp_init(20, k)); end
            total++; if (att !== 4'(k)) begin bad++; $display("FAIL retry_att%0d: got %0d want %0d", k, att, k); end
        end
        total++; if ({a_locked, a_fail, a_attempt} !== 6'b10_0010) begin bad++; $display("FAIL retry_final: got %b want 100010", {a_locked, a_fail, a_attempt}); end
    endtask

    task automatic test_lock_loss();
        int low; int ll0; logic [8:0] ini; logic [3:0] att;
        ll0 = ll_a;
        ifa.clk_status = 3'b000;
        @(negedge clk);
        total++; if (a_lock_lost !== 1'b1) begin bad++; $display("FAIL loss_pulse: got %b want 1", a_lock_lost); end
        total++; if ({a_locked, a_busy, ifa.clk_resetn, ifa.req_ready, a_attempt} !== 8'b0100_0000) begin bad++; $display("FAIL loss_flags: got %b want 01000000", {a_locked, a_busy, ifa.clk_resetn, ifa.req_ready, a_attempt}); end
        total++; if (ifa.clk_init !== 9'd20) begin bad++; $display("FAIL loss_init: got %0d want 20", ifa.clk_init); end
        attempt_a(3'b010, $urandom_range(0, 30), low, ini, att);
        total++; if (low !== RST_A) begin bad++; $display("FAIL loss_low: got %0d want %0d", low, RST_A); end
        total++; if (a_locked !== 1'b1) begin bad++; $display("FAIL loss_relock: got %b want 1", a_locked); end
        total++; if (ll_a - ll0 !== 1) begin bad++; $display("FAIL loss_width: got %0d want 1", ll_a - ll0); end
    endtask

    task automatic test_exhaust();
        bit ok; int low; logic [8:0] ini; logic [3:0] att;
        send_a($urandom, $urandom_range(1, 500), 9'd500, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL exh_accept: got %b want 1", ok); end
        for (int k = 0; k < NTRIES; k++) begin
            attempt_a(3'b100, $urandom_range(0, 20), low, ini, att);
            total++; if (ini !== exp_init(500, k)) begin bad++; $display("FAIL exh_init%0d: got %0d want %0d", k, ini, exp_init(500, k)); end
            total++; if (low !== RST_A) begin bad++; $display("FAIL exh_low%0d: got %0d want %0d", k, low, RST_A); end
        end
        repeat (20) @(negedge clk);
        total++; if ({a_fail, ifa.clk_resetn, ifa.req_ready, a_busy, a_locked, a_attempt} !== 9'b1010_0_0011) begin bad++; $display("FAIL exh_final: got %b want 101000011", {a_fail, ifa.clk_resetn, ifa.req_ready, a_busy, a_locked, a_attempt}); end
    endtask

    task automatic test_new_req_locked();
        bit ok; int low; int ll0; logic [8:0] ini; logic [3:0] att;
        send_a(32'd111, 32'd7, 9'd300, ok);
        attempt_a(3'b010, 5, low, ini, att);
        ll0 = ll_a;
        send_a(32'd222, 32'd9, 9'd45, ok);
        total++; if ({ifa.clk_resetn, a_busy, ifa.req_ready, a_locked} !== 4'b0100) begin bad++; $display("FAIL abort_flags: got %b want 0100", {ifa.clk_resetn, a_busy, ifa.req_ready, a_locked}); end
        total++; if ({ifa.clk_counter, ifa.clk_init} !== {32'd222, 9'd45}) begin bad++; $display("FAIL abort_cfg: got %0d/%0d want 222/45", ifa.clk_counter, ifa.clk_init); end
        attempt_a(3'b010, 3, low, ini, att);
        total++; if (ll_a - ll0 !== 0) begin bad++; $display("FAIL abort_noloss: got %0d want 0", ll_a - ll0); end
        // Lock drops on the same edge a new request arrives.
        ll0 = ll_a;
        ifa.clk_status = 3'b000;
        send_a(32'd333, 32'd4, 9'd77, ok);
        total++; if (a_lock_lost !== 1'b1) begin bad++; $display("FAIL both_pulse: got %b want 1", a_lock_lost); end
        total++; if ({ifa.clk_counter, ifa.clk_init} !== {32'd333, 9'd77}) begin bad++; $display("FAIL both_cfg: got %0d/%0d want 333/77", ifa.clk_counter, ifa.clk_init); end
        attempt_a(3'b010, 3, low, ini, att);
        total++; if (ini !== 9'd77 || low !== RST_A) begin bad++; $display("FAIL both_attempt: got init %0d low %0d want 77 %0d", ini, low, RST_A); end
        total++; if (ll_a - ll0 !== 1) begin bad++; $display("FAIL both_width: got %0d want 1", ll_a - ll0); end
    endtask

    task automatic test_random();
        bit ok; int low; int nerr; int natt; logic [8:0] ini; logic [3:0] att;
        logic [31:0] c; logic [8:0] base; logic [8:0] e;
        for (int n = 0; n < 6; n++) begin
            c = $urandom;
            base = 9'($urandom_range(0, 511));
            nerr = $urandom_range(0, 4);
            natt = (nerr >= NTRIES) ? NTRIES : nerr + 1;
            for (int k = 0; k < natt; k++) exp_q.push_back(exp_init(int'(base), k));
            send_a(c, $urandom_range(1, 1000), base, ok);
            for (int k = 0; k < natt; k++) begin
                attempt_a((k < nerr) ? 3'b100 : {1'($urandom_range(0, 1)), 2'b10}, $urandom_range(0, 40), low, ini, att);
                e = exp_q.pop_front();
                total++; if (ini !== e) begin bad++; $display("FAIL rnd%0d_init%0d: got %0d want %0d", n, k, ini, e); end
                total++; if (att !== 4'(k) || low !== RST_A) begin bad++; $display("FAIL rnd%0d_att%0d: got att %0d low %0d want %0d %0d", n, k, att, low, k, RST_A); end
            end
            total++; if ({a_locked, a_fail} !== ((nerr >= NTRIES) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rnd%0d_outcome: got %b nerr=%0d", n, {a_locked, a_fail}, nerr); end
            total++; if (ifa.clk_counter !== c) begin bad++; $display("FAIL rnd%0d_counter: got %h want %h", n, ifa.clk_counter, c); end
        end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rnd_queue: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok; int n = 0;
        send_a($urandom, 32'd3, 9'($urandom_range(0, 511)), ok);
        ifa.clk_status = 3'b001;
        while (ifa.clk_resetn !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        total++; if (ifa.clk_resetn !== 1'b1) begin bad++; $display("FAIL mid_release: got %b want 1", ifa.clk_resetn); end
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        total++; if ({ifa.req_ready, ifa.clk_resetn, a_locked, a_fail, a_busy, a_attempt, a_lock_lost} !== 10'd0) begin bad++; $display("FAIL mid_ctrl: got %b want 0", {ifa.req_ready, ifa.clk_resetn, a_locked, a_fail, a_busy, a_attempt, a_lock_lost}); end
        total++; if ({ifa.clk_counter, ifa.clk_ref_counter, ifa.clk_init} !== 73'd0) begin bad++; $display("FAIL mid_data: got %h want 0", {ifa.clk_counter, ifa.clk_ref_counter, ifa.clk_init}); end
        resetn = 1'b1;
        ifa.clk_status = 3'b000;
        @(negedge clk);
        total++; if (ifa.req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", ifa.req_ready); end
    endtask

    task automatic test_timeout();
        int low; int high; logic [8:0] base; logic [8:0] ini;
        base = 9'($urandom_range(0, 511));
        ifb.clk_status = 3'b001;
        ifb.req_valid = 1'b1;
        ifb.req_counter = $urandom;
        ifb.req_ref_counter = 32'd10;
        ifb.req_init = base;
        @(negedge clk);
        ifb.req_valid = 1'b0;
        for (int k = 0; k < NTRIES; k++) begin
            low = 0;
            high = 0;
            while (ifb.clk_resetn !== 1'b1 && low < 1000) begin low++; @(negedge clk); end
            ini = ifb.clk_init;
            while (ifb.clk_resetn === 1'b1 && high < 1000) begin high++; @(negedge clk); end
            total++; if (low !== RST_B) begin bad++; $display("FAIL tmo_low%0d: got %0d want %0d", k, low, RST_B); end
            total++; if (high !== TMO_B) begin bad++; $display("FAIL tmo_wait%0d: got %0d want %0d", k, high, TMO_B); end
            total++; if (ini !== exp_init(int'(base), k)) begin bad++; $display("FAIL tmo_init%0d: got %0d want %0d", k, ini, exp_init(int'(base), k)); end
        end
        total++; if ({b_fail, b_locked, b_busy, b_lock_lost, b_attempt, ifb.req_ready} !== 9'b1000_0011_1) begin bad++; $display("FAIL tmo_final: got %b want 100000111", {b_fail, b_locked, b_busy, b_lock_lost, b_attempt, ifb.req_ready}); end
    endtask

    initial begin
        ifa.req_valid = 1'b0; ifa.req_counter = '0; ifa.req_ref_counter = '0; ifa.req_init = '0; ifa.clk_status = '0;
        ifb.req_valid = 1'b0; ifb.req_counter = '0; ifb.req_ref_counter = '0; ifb.req_init = '0; ifb.clk_status = '0;
        @(negedge clk);
        test_reset();
        test_first_lock();
        test_retry_lock();
        test_lock_loss();
        test_exhaust();
        test_new_req_locked();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish before 90000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/clock_cfg_seq.md
Name: clock_cfg_seq

Overview:
- Configuration sequencer directly upstream of the CLOCK generator.
- Accepts a frequency request (target count, reference window, initial tuning word) over a valid/ready handshake.
- Drives CLOCK's resetn/counter/ref_counter/init. Holds CLOCK in reset for a fixed period, then waits for lock with a timeout.
- On failure, retries with a stepped init value; after lock, monitors for lock loss and relocks automatically.

Parameters:
- RST_CYCLES, 100: ref_clk cycles CLOCK is held in reset per attempt (>=1).
- LOCK_TIMEOUT, 1000000: ref_clk cycles allowed per attempt before declaring timeout (32-bit).
- MAX_RETRY, 3: additional attempts after the first (0..15).
- INIT_STEP, 16: amount added to init on each retry (9-bit arithmetic).

Ports:
- ref_clk  in  1  sole clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  new configuration request
- req_ready  out  1  sequencer can accept a request
- req_counter  in  32  target output-clock count
- req_ref_counter  in  32  reference window length
- req_init  in  9  initial tuning word
- clk_resetn  out  1  reset to CLOCK, active-low
- clk_counter  out  32  to CLOCK counter
- clk_ref_counter  out  32  to CLOCK ref_counter
- clk_init  out  9  to CLOCK init
- clk_status  in  3  from CLOCK: [0] searching, [1] locked, [2] lock error
- locked  out  1  CLOCK locked with current config
- fail  out  1  all attempts exhausted
- busy  out  1  attempt in progress
- attempt  out  4  attempts started for the current request, minus 1
- lock_lost  out  1  one-cycle pulse when lock drops in LOCKED

Behaviour:
- Reset values:
  - clk_resetn=0, all clk_* data outputs=0
  - req_ready=0 for the reset cycle, then 1
  - locked=0, fail=0, busy=0, attempt=0, lock_lost=0
  - state=IDLE
- States: IDLE, HOLD, WAIT, LOCKED, FAILED.
- req_ready=1 in IDLE, LOCKED and FAILED; 0 in HOLD and WAIT.
- Handshake: a request is accepted on the cycle req_valid&&req_ready. Inputs are registered into clk_counter/clk_ref_counter/clk_init on that edge. attempt=0, locked=0, fail=0, next state=HOLD.
- A request accepted in LOCKED or FAILED aborts the current config: CLOCK re-enters reset on the next cycle.
- HOLD:
  - clk_resetn=0, busy=1.
  - Hold counter runs RST_CYCLES cycles, then state=WAIT and clk_resetn=1 on the following edge.
  - clk_resetn is low for exactly RST_CYCLES cycles per attempt.
- WAIT:
  - busy=1; timeout counter cleared on entry.
  - clk_status[1]=1 -> LOCKED (locked=1, busy=0) on the next edge.
  - clk_status[2]=1, or timeout counter reaching LOCK_TIMEOUT-1 -> attempt failed.
  - If [1] and [2] are asserted in the same cycle, [1] wins.
- Failed attempt:
  - If attempt<MAX_RETRY: attempt+1, clk_init=clk_init+INIT_STEP (9-bit, wraps modulo 512), state=HOLD.
  - Otherwise: state=FAILED, fail=1, busy=0, clk_resetn held 0.
- LOCKED:
  - Outputs static.
  - If clk_status[1] falls to 0: lock_lost pulses for 1 cycle, locked=0, attempt=0, clk_init restored to the last accepted req_init, state=HOLD.
  - A simultaneous new request takes priority over relock; lock_lost still pulses.
- FAILED: terminal until a new request or reset.
- resetn low in any state returns all registers to reset values on that edge. An in-flight attempt is discarded; CLOCK is forced into reset.
- Counters: hold counter width fits RST_CYCLES; timeout counter 32 bits, saturating, never wraps.

Test Plan:
- Lock on first try: req(counter=5000, ref=10, init=20), model asserts status[1] 300 cycles after release -> clk_resetn low exactly 100 cycles, clk_init=20, locked=1, attempt=0, fail=0.
- Retry then lock: model asserts status[2] on attempts 0 and 1, then status[1] -> clk_init sequence 20, 36, 52; attempt=2; locked=1.
- Exhaustion with wrap: init=500, status[2] every attempt -> clk_init 500, 4, 20, 36 (wrap), then fail=1, clk_resetn=0, req_ready=1.
- Timeout: LOCK_TIMEOUT=50, model never responds -> each WAIT lasts exactly 50 cycles; fail after 4 attempts.
- Lock loss: after lock, drop status[1] -> lock_lost single pulse, clk_init restored to 20, HOLD re-entered, relock achieved.
- Mid-operation reset/request: resetn=0 during WAIT -> next cycle all outputs at reset values. New request in LOCKED -> immediate HOLD with new counter value; req_ready=0 during HOLD/WAIT.
